// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the MEM-stage data memory.
// Imported by data_memory and data_mem_addr_decode.
package mem_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned DATA_MEM_BASE  = 1024;
  localparam int unsigned DATA_MEM_DEPTH = 64;

endpackage

// File: rtl/data_mem_addr_decode.sv
// Byte address to word index and in-range flag for data_memory.
// DEPTH is assumed a power of two so the index wraps modulo DEPTH.
module data_mem_addr_decode
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DATA_MEM_BASE,
  parameter int unsigned DEPTH     = DATA_MEM_DEPTH,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [31:0]   address,
  output logic [AW-1:0] index,
  output logic          in_range
);

  logic [31:0] offset;
  logic [29:0] widx;
  logic        unused_lsbs;

  assign offset      = address - BASE_ADDR;
  assign widx        = offset[31:2];
  assign unused_lsbs = ^offset[1:0];

  // Addresses below the base wrap to huge indices and fail this compare.
  assign in_range = ({2'b00, widx} < 32'(DEPTH));
  assign index    = widx[AW-1:0];

endmodule

// File: rtl/data_memory.sv
// Word-organised MEM-stage data memory: sync store, combinational load.
// DATA_MEMORY_BOUNDS_CHECK_EN drops out-of-range accesses instead of aliasing.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DATA_MEM_BASE,
  parameter int unsigned DEPTH     = DATA_MEM_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  word_t storeValue,
  input  logic [31:0] address,
  input  logic  MEM_W_EN,
  input  logic  MEM_R_EN,
  output word_t loadValue
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  idx;
  logic           in_range;
  logic           acc_ok;

  data_mem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_dec (
    .address  (address),
    .index    (idx),
    .in_range (in_range)
  );

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  assign acc_ok = in_range;
`else
  logic unused_range;
  assign unused_range = in_range;
  assign acc_ok       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (MEM_W_EN && acc_ok) begin
      mem_q[idx] <= storeValue;
    end
  end

  // No write bypass: a same-cycle load sees the pre-edge word.
  always_comb begin
    loadValue = '0;
    if (MEM_R_EN && acc_ok) begin
      loadValue = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory with a behavioural word-array model.
// Honours DATA_MEMORY_BOUNDS_CHECK_EN the same way the design does.
module tb_data_memory;

  localparam int unsigned BASE  = 1024;
  localparam int unsigned DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] storeValue;
  logic [31:0] address;
  logic        MEM_W_EN;
  logic        MEM_R_EN;
  logic [31:0] loadValue;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [DEPTH];

  data_memory #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .storeValue (storeValue),
    .address    (address),
    .MEM_W_EN   (MEM_W_EN),
    .MEM_R_EN   (MEM_R_EN),
    .loadValue  (loadValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off / 4;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a,
                                        input logic ren);
    int unsigned w;
    w = word_of(a);
    if (!ren) return 32'h0;
    if (w >= DEPTH) begin
      if (BOUNDS) return 32'h0;
      w = w % DEPTH;
    end
    return model[w];
  endfunction

  function automatic void mwrite(input logic [31:0] a,
                                 input logic [31:0] d);
    int unsigned w;
    w = word_of(a);
    if (w >= DEPTH) begin
      if (BOUNDS) return;
      w = w % DEPTH;
    end
    model[w] = d;
  endfunction

  function automatic void mclear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
  endfunction

  // One rising edge; the model follows the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && MEM_W_EN) mwrite(address, storeValue);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    address = BASE;
    storeValue = 32'h0;
    mclear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    MEM_R_EN = 1'b1;
    address = BASE;
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL reset_word0: got %h want %h", loadValue, 32'h0);
    end
    address = BASE + 4 * (DEPTH - 1);
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL reset_last: got %h want %h", loadValue, 32'h0);
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    storeValue = 32'd10;
    address = 32'd1024;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    tick();
    tick();
    address = 32'd1029;
    tick();
    tick();
    @(negedge clk);
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b1;
    address = 32'd1024;
    #1;
    checks++;
    if (loadValue !== 32'd10) begin
      errors++;
      $display("FAIL store_w0: got %0d want 10", loadValue);
    end
    address = 32'd1028;
    #1;
    checks++;
    if (loadValue !== 32'd10) begin
      errors++;
      $display("FAIL store_w1: got %0d want 10", loadValue);
    end
  endtask

  task automatic test_unaligned_load();
    @(negedge clk);
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
    address = 32'd1025;
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL unal_ren0: got %h want 0", loadValue);
    end
    MEM_R_EN = 1'b1;
    #1;
    checks++;
    if (loadValue !== 32'd10) begin
      errors++;
      $display("FAIL unal_ren1: got %0d want 10", loadValue);
    end
    address = 32'd1031;
    #1;
    checks++;
    if (loadValue !== 32'd10) begin
      errors++;
      $display("FAIL unal_1031: got %0d want 10", loadValue);
    end
  endtask

  task automatic test_rw_same_cycle();
    @(negedge clk);
    address = 32'd1032;
    storeValue = 32'd5;
    MEM_W_EN = 1'b1;
    MEM_R_EN = 1'b0;
    tick();
    @(negedge clk);
    storeValue = 32'd7;
    MEM_R_EN = 1'b1;
    #1;
    checks++;
    if (loadValue !== 32'd5) begin
      errors++;
      $display("FAIL rw_before: got %0d want 5", loadValue);
    end
    tick();
    checks++;
    if (loadValue !== 32'd7) begin
      errors++;
      $display("FAIL rw_after: got %0d want 7", loadValue);
    end
    @(negedge clk);
    MEM_W_EN = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b1;
    address = 32'd1024;
    #1;
    rst_n = 1'b0;
    mclear();
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL arst_during: got %h want 0", loadValue);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL arst_w0: got %h want 0", loadValue);
    end
    address = 32'd1028;
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL arst_w1: got %h want 0", loadValue);
    end
    // Reset held across an edge with a pending write discards the write.
    @(negedge clk);
    rst_n = 1'b0;
    address = 32'd1036;
    storeValue = 32'hDEAD_BEEF;
    MEM_W_EN = 1'b1;
    tick();
    @(negedge clk);
    MEM_W_EN = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (loadValue !== 32'h0) begin
      errors++;
      $display("FAIL arst_wdrop: got %h want 0", loadValue);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] w0_exp;
    logic [31:0] oob_exp;
    @(negedge clk);
    address = 32'd1024;
    storeValue = 32'd10;
    MEM_W_EN = 1'b1;
    tick();
    @(negedge clk);
    address = 32'd1280;
    storeValue = 32'd99;
    tick();
    @(negedge clk);
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b1;
    w0_exp  = BOUNDS ? 32'd10 : 32'd99;
    oob_exp = BOUNDS ? 32'd0  : 32'd99;
    address = 32'd1024;
    #1;
    checks++;
    if (loadValue !== w0_exp) begin
      errors++;
      $display("FAIL bnd_w0: got %0d want %0d", loadValue, w0_exp);
    end
    address = 32'd1280;
    #1;
    checks++;
    if (loadValue !== oob_exp) begin
      errors++;
      $display("FAIL bnd_1280: got %0d want %0d", loadValue, oob_exp);
    end
    address = 32'd1020;
    #1;
    checks++;
    if (loadValue !== mread(32'd1020, 1'b1)) begin
      errors++;
      $display("FAIL bnd_below: got %h want %h",
               loadValue, mread(32'd1020, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int sel;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      sel = $urandom_range(0, 9);
      if (sel < 7)
        address = BASE + $urandom_range(0, 4 * DEPTH - 1);
      else if (sel < 9)
        address = BASE + 4 * DEPTH + $urandom_range(0, 4 * DEPTH - 1);
      else
        address = $urandom;
      storeValue = $urandom;
      MEM_W_EN = ($urandom_range(0, 1) == 1);
      MEM_R_EN = ($urandom_range(0, 3) != 0);
      #1;
      exp = mread(address, MEM_R_EN);
      checks++;
      if (loadValue !== exp) begin
        errors++;
        $display("FAIL rnd_pre[%0d] a=%h: got %h want %h",
                 n, address, loadValue, exp);
      end
      tick();
      exp = mread(address, MEM_R_EN);
      checks++;
      if (loadValue !== exp) begin
        errors++;
        $display("FAIL rnd_post[%0d] a=%h: got %h want %h",
                 n, address, loadValue, exp);
      end
    end
    @(negedge clk);
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_unaligned_load();
    test_rw_same_cycle();
    test_async_reset();
    test_bounds();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
